// File: rtl/bram_arb_pkg.sv
// bram_arb_pkg
// Shared definitions for the two-requester BRAM port arbiter.
//   BRAM_ADDR_WIDTH / BRAM_DATA_WIDTH : default BRAM word-address and word widths
//   bram_req_t                         : one request {writeEn, addr, data} at default widths
//   RR_RESET_LAST                      : "last granted" value loaded at reset
package bram_arb_pkg;

    localparam int BRAM_ADDR_WIDTH = 10;
    localparam int BRAM_DATA_WIDTH = 36;

    typedef struct packed {
        logic                       writeEn;
        logic [BRAM_ADDR_WIDTH-1:0] addr;
        logic [BRAM_DATA_WIDTH-1:0] data;
    } bram_req_t;

    // Pretend requester 1 was granted last, so requester 0 wins the first tie.
    localparam logic RR_RESET_LAST = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2
// Two-way round-robin arbiter. The pointer only moves when the caller reports
// that the grant was actually used (i_advance), so a stalled grant keeps its
// priority position.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_elig[1:0]    : requester eligible this cycle
//   i_advance      : a transfer happened on the current grant
//   o_grant[1:0]   : one-hot (or zero) grant
module rr_arbiter2
    import bram_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_elig,
    input  logic       i_advance,
    output logic [1:0] o_grant
);

    // Index of the requester granted most recently.
    logic r_last;

    always_comb begin
        o_grant = 2'b00;
        case (i_elig)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = r_last ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last <= RR_RESET_LAST;
        end else if (i_advance) begin
            r_last <= o_grant[1];
        end
    end

endmodule

// File: rtl/bram_tdp_arbiter.sv
// bram_tdp_arbiter
// Shares one synchronous BRAM port between two requesters.
// Handshake rule (all request and response channels): a transfer happens on a
// rising clock edge where valid and ready are both 1; an unaccepted request may
// change or drop, and nothing is latched from it.
//   clock, reset_n                     : single clock, asynchronous active-low reset
//   io_reqN_valid/ready/writeEn/addr/dataIn : request channel of requester N
//   io_respN_valid/ready/dataOut      : read response channel of requester N
//   io_bram_en/writeEn/addr/dataIn    : BRAM port controls, driven in the accept cycle
//   io_bram_dataOut                    : BRAM read data, one cycle after an enabled read
module bram_tdp_arbiter
    import bram_arb_pkg::*;
#(
    parameter int ADDR_WIDTH = BRAM_ADDR_WIDTH,
    parameter int DATA_WIDTH = BRAM_DATA_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  io_req0_valid,
    output logic                  io_req0_ready,
    input  logic                  io_req0_writeEn,
    input  logic [ADDR_WIDTH-1:0] io_req0_addr,
    input  logic [DATA_WIDTH-1:0] io_req0_dataIn,
    output logic                  io_resp0_valid,
    input  logic                  io_resp0_ready,
    output logic [DATA_WIDTH-1:0] io_resp0_dataOut,
    input  logic                  io_req1_valid,
    output logic                  io_req1_ready,
    input  logic                  io_req1_writeEn,
    input  logic [ADDR_WIDTH-1:0] io_req1_addr,
    input  logic [DATA_WIDTH-1:0] io_req1_dataIn,
    output logic                  io_resp1_valid,
    input  logic                  io_resp1_ready,
    output logic [DATA_WIDTH-1:0] io_resp1_dataOut,
    output logic                  io_bram_en,
    output logic                  io_bram_writeEn,
    output logic [ADDR_WIDTH-1:0] io_bram_addr,
    output logic [DATA_WIDTH-1:0] io_bram_dataIn,
    input  logic [DATA_WIDTH-1:0] io_bram_dataOut
);

    logic [1:0]            r_inflight;
    logic [1:0]            r_resp_valid;
    logic [DATA_WIDTH-1:0] r_resp_data [2];

    logic [1:0]            w_elig;
    logic [1:0]            w_grant;
    logic [1:0]            w_resp_ready;
    logic                  w_xfer;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_data;

    // Writes are always eligible; a read waits until this requester has no read
    // in flight and no response waiting. The other requester's state is ignored.
    assign w_elig[0] = io_req0_valid & (io_req0_writeEn | (~r_inflight[0] & ~r_resp_valid[0]));
    assign w_elig[1] = io_req1_valid & (io_req1_writeEn | (~r_inflight[1] & ~r_resp_valid[1]));

    // A grant only goes to an eligible (hence valid) requester, so any grant is a transfer.
    assign w_xfer = |w_grant;

    rr_arbiter2 u_rr (
        .i_clk     (clock),
        .i_rst_n   (reset_n),
        .i_elig    (w_elig),
        .i_advance (w_xfer),
        .o_grant   (w_grant)
    );

    assign io_req0_ready = w_grant[0];
    assign io_req1_ready = w_grant[1];

    assign w_sel_we   = w_grant[1] ? io_req1_writeEn : io_req0_writeEn;
    assign w_sel_addr = w_grant[1] ? io_req1_addr    : io_req0_addr;
    assign w_sel_data = w_grant[1] ? io_req1_dataIn  : io_req0_dataIn;

    assign io_bram_en      = w_xfer;
    assign io_bram_writeEn = w_xfer & w_sel_we;
    assign io_bram_addr    = w_sel_addr;
    assign io_bram_dataIn  = w_sel_data;

    assign w_resp_ready = {io_resp1_ready, io_resp0_ready};

    // Read accepted at t: in flight during t+1, BRAM data captured at the end of
    // t+1, response presented from t+2 until consumed.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_inflight   <= 2'b00;
            r_resp_valid <= 2'b00;
            for (int n = 0; n < 2; n++) begin
                r_resp_data[n] <= '0;
            end
        end else begin
            r_inflight[0] <= w_grant[0] & ~io_req0_writeEn;
            r_inflight[1] <= w_grant[1] & ~io_req1_writeEn;
            for (int n = 0; n < 2; n++) begin
                if (r_inflight[n]) begin
                    r_resp_valid[n] <= 1'b1;
                    r_resp_data[n]  <= io_bram_dataOut;
                end else if (r_resp_valid[n] && w_resp_ready[n]) begin
                    r_resp_valid[n] <= 1'b0;
                end
            end
        end
    end

    assign io_resp0_valid   = r_resp_valid[0];
    assign io_resp1_valid   = r_resp_valid[1];
    assign io_resp0_dataOut = r_resp_data[0];
    assign io_resp1_dataOut = r_resp_data[1];

endmodule

// File: tb/tb_bram_tdp_arbiter.sv
// tb_bram_tdp_arbiter
// Bench for bram_tdp_arbiter: behavioural BRAM, directed phases followed by
// random traffic, and a per-cycle monitor comparing the DUT against a
// transaction-level reference model (memory array, pending-read flags, queues
// of expected read responses with their accept cycle).
module tb_bram_tdp_arbiter;

  localparam int AW = 10;
  localparam int DW = 36;

  logic          clock;
  logic          reset_n;
  logic          req0_valid, req0_ready, req0_we;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_din;
  logic          resp0_valid, resp0_ready;
  logic [DW-1:0] resp0_dout;
  logic          req1_valid, req1_ready, req1_we;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_din;
  logic          resp1_valid, resp1_ready;
  logic [DW-1:0] resp1_dout;
  logic          bram_en, bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_din;
  logic [DW-1:0] bram_dout;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bram_tdp_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .io_req0_valid    (req0_valid),
    .io_req0_ready    (req0_ready),
    .io_req0_writeEn  (req0_we),
    .io_req0_addr     (req0_addr),
    .io_req0_dataIn   (req0_din),
    .io_resp0_valid   (resp0_valid),
    .io_resp0_ready   (resp0_ready),
    .io_resp0_dataOut (resp0_dout),
    .io_req1_valid    (req1_valid),
    .io_req1_ready    (req1_ready),
    .io_req1_writeEn  (req1_we),
    .io_req1_addr     (req1_addr),
    .io_req1_dataIn   (req1_din),
    .io_resp1_valid   (resp1_valid),
    .io_resp1_ready   (resp1_ready),
    .io_resp1_dataOut (resp1_dout),
    .io_bram_en       (bram_en),
    .io_bram_writeEn  (bram_we),
    .io_bram_addr     (bram_addr),
    .io_bram_dataIn   (bram_din),
    .io_bram_dataOut  (bram_dout)
  );

  // ---------------- clock ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- behavioural BRAM (one synchronous port) ----------------
  logic [DW-1:0] bmem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bram_en) begin
      if (bram_we) bmem[bram_addr] <= bram_din;
      else         bram_dout <= bmem[bram_addr];
    end
  end

  // ---------------- reference model state ----------------
  logic [DW-1:0] mmem [0:(1<<AW)-1];
  bit            pend [2];
  int            last_g;
  logic [DW-1:0] exp_q0 [$];
  logic [DW-1:0] exp_q1 [$];
  int            acc_q0 [$];
  int            acc_q1 [$];

  function automatic int q_size(input int n);
    return (n == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  function automatic int q_acc(input int n);
    return (n == 0) ? acc_q0[0] : acc_q1[0];
  endfunction

  function automatic logic [DW-1:0] q_data(input int n);
    return (n == 0) ? exp_q0[0] : exp_q1[0];
  endfunction

  task automatic q_pop(input int n);
    if (n == 0) begin
      void'(exp_q0.pop_front());
      void'(acc_q0.pop_front());
    end else begin
      void'(exp_q1.pop_front());
      void'(acc_q1.pop_front());
    end
  endtask

  task automatic q_push(input int n, input logic [DW-1:0] d, input int c);
    if (n == 0) begin
      exp_q0.push_back(d);
      acc_q0.push_back(c);
    end else begin
      exp_q1.push_back(d);
      acc_q1.push_back(c);
    end
  endtask

  task automatic model_reset();
    exp_q0.delete();
    exp_q1.delete();
    acc_q0.delete();
    acc_q1.delete();
    pend[0] = 0;
    pend[1] = 0;
    last_g  = 1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      #2;
      cyc++;
      if (!reset_n) begin
        chk("rst_ready", {62'd0, req1_ready, req0_ready}, 64'd0);
        chk("rst_bram", {62'd0, bram_en, bram_we}, 64'd0);
        chk("rst_resp_valid", {62'd0, resp1_valid, resp0_valid}, 64'd0);
        chk("rst_resp0_data", {28'd0, resp0_dout}, 64'd0);
        chk("rst_resp1_data", {28'd0, resp1_dout}, 64'd0);
        model_reset();
      end else begin
        bit            e0, e1, ev;
        int            g;
        logic          gwe, rv, rr;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd, rd;

        // Arbitration decision from the model's view of outstanding reads.
        e0 = req0_valid && (req0_we || !pend[0]);
        e1 = req1_valid && (req1_we || !pend[1]);
        g  = -1;
        if (e0 && e1) g = (last_g == 0) ? 1 : 0;
        else if (e0)  g = 0;
        else if (e1)  g = 1;
        gwe = (g == 1) ? req1_we   : req0_we;
        ga  = (g == 1) ? req1_addr : req0_addr;
        gd  = (g == 1) ? req1_din  : req0_din;

        chk("ready0", {63'd0, req0_ready}, {63'd0, g == 0});
        chk("ready1", {63'd0, req1_ready}, {63'd0, g == 1});
        chk("bram_en", {63'd0, bram_en}, {63'd0, g >= 0});
        if (g >= 0) begin
          chk("bram_we", {63'd0, bram_we}, {63'd0, gwe});
          chk("bram_addr", {54'd0, bram_addr}, {54'd0, ga});
          chk("bram_din", {28'd0, bram_din}, {28'd0, gd});
        end else begin
          chk("bram_we_idle", {63'd0, bram_we}, 64'd0);
        end

        // Responses: presented from accept+2, held until consumed.
        for (int n = 0; n < 2; n++) begin
          rv = (n == 0) ? resp0_valid : resp1_valid;
          rd = (n == 0) ? resp0_dout  : resp1_dout;
          rr = (n == 0) ? resp0_ready : resp1_ready;
          ev = (q_size(n) > 0) && (cyc >= q_acc(n) + 2);
          chk((n == 0) ? "resp0_valid" : "resp1_valid", {63'd0, rv}, {63'd0, ev});
          if (ev) begin
            chk((n == 0) ? "resp0_data" : "resp1_data", {28'd0, rd}, {28'd0, q_data(n)});
            if (rr) begin
              q_pop(n);
              pend[n] = 0;
            end
          end
        end

        // Commit the transfer into the model.
        if (g >= 0) begin
          if (gwe) begin
            mmem[ga] = gd;
          end else begin
            q_push(g, mmem[ga], cyc);
            pend[g] = 1;
          end
          last_g = g;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clock);
  endtask

  task automatic set_req(input int n, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_addr = a; req0_din = d;
    end else begin
      req1_valid = v; req1_we = we; req1_addr = a; req1_din = d;
    end
  endtask

  task automatic idle();
    set_req(0, 1'b0, 1'b0, '0, '0);
    set_req(1, 1'b0, 1'b0, '0, '0);
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[DW-1:0];
  endfunction

  task automatic rand_req(input int n, input bit allow_write);
    logic [AW-1:0] a;
    logic          v, we;
    int            r;
    r  = $urandom_range(0, 9);
    a  = (r > 7) ? 10'h3FF : AW'(r);
    v  = ($urandom_range(0, 3) != 0);
    we = allow_write ? 1'($urandom_range(0, 1)) : 1'b0;
    set_req(n, v, we, a, rand_data());
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_n = 1'b0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    idle();
    repeat (3) step();
    reset_n = 1'b1;

    // Single write, then read back the same word.
    step(); set_req(0, 1'b1, 1'b1, 10'h005, 36'h123456789);
    step(); idle();
    step(); set_req(0, 1'b1, 1'b0, 10'h005, '0);
    step(); idle();
    repeat (3) step();

    // Preload the addresses used by the random traffic.
    for (int i = 0; i < 8; i++) begin
      step(); set_req(i % 2, 1'b1, 1'b1, AW'(i), rand_data());
      set_req(1 - (i % 2), 1'b0, 1'b0, '0, '0);
    end
    step(); idle();

    // Both requesters reading every cycle.
    for (int i = 0; i < 12; i++) begin
      step();
      set_req(0, 1'b1, 1'b0, AW'($urandom_range(0, 7)), '0);
      set_req(1, 1'b1, 1'b0, AW'($urandom_range(0, 7)), '0);
    end
    step(); idle();
    repeat (3) step();

    // Requester 1 holds its response while requester 0 keeps writing.
    resp1_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      set_req(1, 1'b1, 1'b0, 10'h002, '0);
      set_req(0, 1'b1, 1'b1, AW'($urandom_range(0, 7)), rand_data());
    end
    resp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      set_req(0, 1'b1, 1'b1, AW'($urandom_range(0, 7)), rand_data());
    end
    step(); idle();
    repeat (3) step();

    // Write then read the top address on consecutive cycles.
    step(); set_req(0, 1'b1, 1'b1, 10'h3FF, 36'hA5A5_0F0F_3);
    step(); set_req(0, 1'b1, 1'b0, 10'h3FF, '0);
    step(); idle();
    repeat (3) step();

    // Reset right after a read is accepted; then both request at once.
    step(); set_req(1, 1'b1, 1'b0, 10'h003, '0);
    step(); idle(); reset_n = 1'b0;
    step();
    step(); reset_n = 1'b1;
    step();
    set_req(0, 1'b1, 1'b0, 10'h001, '0);
    set_req(1, 1'b1, 1'b0, 10'h004, '0);
    step(); idle();
    repeat (4) step();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step();
      rand_req(0, 1'b1);
      rand_req(1, 1'b1);
      resp0_ready = ($urandom_range(0, 3) != 0);
      resp1_ready = ($urandom_range(0, 3) != 0);
    end

    // Drain outstanding responses.
    step(); idle();
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    repeat (8) step();
    #4;
    chk("drain0", 64'(exp_q0.size()), 64'd0);
    chk("drain1", 64'(exp_q1.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bram_tdp_arbiter.md
BRAM_TDP_ARBITER -- requirements
Module: bram_tdp_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, BRAM word-address width.
REQ-002 Parameter DATA_WIDTH, default 36, BRAM word width.
REQ-003 Design intent: one clock; reset is asynchronous and active-low.
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 io_reqN_valid  input  1  requester N (N=0,1) presents a request.
REQ-007 io_reqN_ready  output  1  request N is accepted this cycle.
REQ-008 io_reqN_writeEn  input  1  1=write, 0=read.
REQ-009 io_reqN_addr  input  ADDR_WIDTH  word address.
REQ-010 io_reqN_dataIn  input  DATA_WIDTH  write data.
REQ-011 io_respN_valid  output  1  read data for requester N is held.
REQ-012 io_respN_ready  input  1  requester N consumes its response.
REQ-013 io_respN_dataOut  output  DATA_WIDTH  read data.
REQ-014 io_bram_en, io_bram_writeEn  output  1  BRAM port enable and write strobe.
REQ-015 io_bram_addr  output  ADDR_WIDTH; io_bram_dataIn  output  DATA_WIDTH  BRAM port address and write data.
REQ-016 io_bram_dataOut  input  DATA_WIDTH  BRAM read data, valid one cycle after an enabled read.

Function
REQ-017 The block shall share one BRAM port between requesters 0 and 1 using valid/ready handshakes; a transfer occurs when valid and ready are both 1.
REQ-018 Requester N shall be eligible when valid is 1 and either writeEn is 1, or (inflightN==0 and io_respN_valid==0).
REQ-019 At most one ready shall be 1 per cycle; with both eligible, grant goes to the requester not granted most recently; with one eligible, it is granted.
REQ-020 The round-robin pointer shall update only on a transfer.
REQ-021 On transfer, io_bram_en=1 and writeEn/addr/dataIn shall be driven combinationally from the granted request in the same cycle; otherwise io_bram_en=0, io_bram_writeEn=0.
REQ-022 A read accepted in cycle t shall set inflightN for cycle t+1, capture io_bram_dataOut into respN at the end of t+1, and assert io_respN_valid from t+2.
REQ-023 io_respN_valid and io_respN_dataOut shall hold stable until io_respN_ready=1, then deassert the next cycle.
REQ-024 Writes shall produce no response; write latency to BRAM is 0 cycles after acceptance.
REQ-025 A read to an address written in the previous cycle shall return the new data, per BRAM read-after-write ordering on one port.
REQ-026 Requester N's read eligibility shall not depend on requester M's response state.
REQ-027 An unaccepted request may change or drop; the block shall not latch any request fields.

Reset
REQ-028 While reset_n=0: ready=0, io_bram_en=0, io_bram_writeEn=0, io_respN_valid=0, io_respN_dataOut=0, inflight=0, RR pointer favours requester 0.
REQ-029 Reset asserted mid-operation shall discard in-flight reads and held responses; no response appears after release.

Structure
REQ-030 Shared package bram_arb_pkg shall hold ADDR_WIDTH/DATA_WIDTH defaults and the request typedef {writeEn, addr, data}.
REQ-031 Grant logic shall be sub-module rr_arbiter2 (2 eligible-in, 2 grant-out, transfer-advanced pointer).

Verification
REQ-032 After reset, req0 write addr 0x005 data 0x123456789 -> bram_en=1, writeEn=1 in the same cycle; no resp0.
REQ-033 req0 read addr 0x005 accepted at t -> resp0_valid at t+2 with 0x123456789.
REQ-034 Both valid reads every cycle, resp_ready=1 -> grants alternate 0,1,0,1; each requester at most one read in flight.
REQ-035 resp1_ready=0 holding a response, req1 read valid -> ready1=0 until resp consumed; req0 writes continue each cycle.
REQ-036 Write then read addr 0x3FF on consecutive cycles -> read returns the written data.
REQ-037 reset_n low in cycle after a read accept -> resp_valid never asserts; after release first grant goes to requester 0.
